// File: rtl/front_panel_pkg.sv
// Shared constants and helpers for the front-panel switch scanner.
package front_panel_pkg;

    localparam int NUM_ROWS = 3;
    localparam int NUM_COLS = 8;

    // Row indices; encoding 3 is never produced and is treated as row 0.
    typedef enum logic [1:0] {
        ROW_ADDR_LO = 2'd0,
        ROW_ADDR_HI = 2'd1,
        ROW_CTL     = 2'd2
    } row_e;

    // Control switch bit positions on row 2.
    localparam int CTL_STOP         = 0;
    localparam int CTL_RUN          = 1;
    localparam int CTL_SINGLE_STEP  = 2;
    localparam int CTL_EXAMINE      = 3;
    localparam int CTL_EXAMINE_NEXT = 4;
    localparam int CTL_DEPOSIT      = 5;
    localparam int CTL_DEPOSIT_NEXT = 6;
    localparam int CTL_PANEL_RESET  = 7;

    // Row that follows the given one in the scan sequence.
    function automatic row_e next_row(input row_e r);
        case (r)
            ROW_ADDR_LO: next_row = ROW_ADDR_HI;
            ROW_ADDR_HI: next_row = ROW_CTL;
            default:     next_row = ROW_ADDR_LO;
        endcase
    endfunction

    // Active-low one-hot drive pattern for a row.
    function automatic logic [NUM_ROWS-1:0] row_drive(input row_e r);
        case (r)
            ROW_ADDR_HI: row_drive = 3'b101;
            ROW_CTL:     row_drive = 3'b011;
            default:     row_drive = 3'b110;
        endcase
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// Single switch debounce cell: a stable level plus a count of consecutive
// differing samples; the level flips once DEBOUNCE_SCANS samples in a row disagree.
module switch_debounce #(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic sample_en_i,
    input  logic sample_i,
    output logic stable_o,
    output logic rise_o
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SCANS - 1);

    logic          stable_q;
    logic [CW-1:0] cnt_q;
    logic          rise_q;

    // Count disagreeing samples; agreement or an accepted flip clears the count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            if (sample_en_i) begin
                if (sample_i == stable_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_LAST) begin
                    stable_q <= sample_i;
                    cnt_q    <= '0;
                    rise_q   <= sample_i;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = rise_q;

endmodule

// File: rtl/front_panel_switch_scanner.sv
// Front-panel switch matrix scanner: drives rows one at a time, synchronizes
// and debounces the columns, and presents registered levels and press pulses.
module front_panel_switch_scanner
    import front_panel_pkg::*;
#(
    parameter int ROW_CYCLES     = 256,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                         clk,
    input  logic                         resetn,
    output logic [NUM_ROWS-1:0]          row_n,
    input  logic [NUM_COLS-1:0]          col_n,
    output logic [2*NUM_COLS-1:0]        sense_sw,
    output logic [NUM_COLS-1:0]          ctl_level,
    output logic [NUM_COLS-1:0]          ctl_pulse,
    output logic                         frame_done
);

    localparam int NUM_SW = NUM_ROWS * NUM_COLS;
    localparam int CNT_W  = $clog2(ROW_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROW_CYCLES - 1);

    logic [NUM_COLS-1:0] col_meta_q, col_sync_q;
    row_e                row_q, row_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                run_q, run_d;
    logic                sample_en;
    logic [NUM_ROWS-1:0] row_hit;
    logic [NUM_ROWS-1:0] row_sample_en;
    logic [NUM_SW-1:0]   stable;
    logic [NUM_SW-1:0]   rise;
    logic                ctl_sample_q;
    logic [2*NUM_COLS-1:0] sense_q;
    logic [NUM_COLS-1:0] ctl_level_q, ctl_pulse_q;
    logic                frame_done_q;

    // Two-flop synchronizer for the asynchronous column inputs (idle high).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            col_meta_q <= '1;
            col_sync_q <= '1;
        end else begin
            col_meta_q <= col_n;
            col_sync_q <= col_meta_q;
        end
    end

    // Scan state register: idle flag, current row and in-row cycle count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run_q <= 1'b0;
            row_q <= ROW_ADDR_LO;
            cnt_q <= '0;
        end else begin
            run_q <= run_d;
            row_q <= row_d;
            cnt_q <= cnt_d;
        end
    end

    // Scan next state: leave idle on the first edge, sample and advance on the last count.
    always_comb begin
        run_d     = 1'b1;
        row_d     = row_q;
        cnt_d     = cnt_q;
        sample_en = 1'b0;
        if (run_q) begin
            if (cnt_q == CNT_LAST) begin
                sample_en = 1'b1;
                cnt_d     = '0;
                row_d     = next_row(row_q);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign row_hit       = ~row_drive(row_q);
    assign row_sample_en = {NUM_ROWS{sample_en}} & row_hit;
    assign row_n         = run_q ? row_drive(row_q) : '1;

    // One debounce cell per switch; cell gi sits on row gi/8, column gi%8.
    generate
        for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_sw
            switch_debounce #(
                .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
            ) u_db (
                .clk        (clk),
                .resetn     (resetn),
                .sample_en_i(row_sample_en[gi / NUM_COLS]),
                .sample_i   (~col_sync_q[gi % NUM_COLS]),
                .stable_o   (stable[gi]),
                .rise_o     (rise[gi])
            );
        end
    endgenerate

    // Output registers: one clock behind the debounce state so that levels,
    // pulses and frame_done for row 2 all appear in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sense_q      <= '0;
            ctl_level_q  <= '0;
            ctl_pulse_q  <= '0;
            ctl_sample_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            sense_q      <= stable[2*NUM_COLS-1:0];
            ctl_level_q  <= stable[NUM_SW-1:2*NUM_COLS];
            ctl_pulse_q  <= rise[NUM_SW-1:2*NUM_COLS];
            ctl_sample_q <= row_sample_en[ROW_CTL];
            frame_done_q <= ctl_sample_q;
        end
    end

    assign sense_sw   = sense_q;
    assign ctl_level  = ctl_level_q;
    assign ctl_pulse  = ctl_pulse_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/front_panel_switch_scanner.md
Name: front_panel_switch_scanner

Overview:
- Input-side companion to the front-panel LED row/column multiplexer: scans the panel switch matrix, debounces it, and presents clean values to the machine.
- Drives one row line low at a time and reads 8 active-low column lines.
- Row 0/1 carry the 16 sense/address switches; row 2 carries the 8 momentary control switches.
- Outputs are sense levels, control levels and one-clock press pulses, consumed by the altair front-panel control logic.

Parameters:
- ROW_CYCLES, 256: clk cycles each row is driven; must be >=4.
- DEBOUNCE_SCANS, 4: consecutive full frames a new value must persist before it is accepted; must be >=1.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- row_n  out  3  row drive, active-low one-hot; 3'b111 = idle.
- col_n  in  8  column sense, active-low (pulled up; 0 = switch closed); asynchronous to clk.
- sense_sw  out  16  debounced address/data switches; [7:0] from row 0, [15:8] from row 1; 1 = closed.
- ctl_level  out  8  debounced control switch levels from row 2. Bit map: 0 stop, 1 run, 2 single_step, 3 examine, 4 examine_next, 5 deposit, 6 deposit_next, 7 panel_reset.
- ctl_pulse  out  8  one-clk pulse per control bit on its debounced 0->1 transition.
- frame_done  out  1  one-clk pulse after the row 2 sample of each frame.

Behaviour:
- Reset, asynchronous, applies at any time including mid-row:
  - row_n=3'b111; sense_sw=0; ctl_level=0; ctl_pulse=0; frame_done=0.
  - Row index=0; cycle counter=0; all debounce counters=0; sync flops=8'hFF.
- First clk edge after reset release: row_n=3'b110 (row 0).
- col_n passes through a 2-FF synchronizer, reset value 8'hFF.
- Scan counter counts 0..ROW_CYCLES-1 for each row:
  - The sample is taken when the count = ROW_CYCLES-1, from the synchronized, inverted columns.
  - On that same edge the row index advances 0->1->2->0 and row_n changes.
  - Row period = ROW_CYCLES cycles; frame = 3*ROW_CYCLES cycles.
- Debounce is per switch bit (24 bits), one small counter each, width clog2(DEBOUNCE_SCANS+1):
  - Sample equals stable value: counter cleared.
  - Sample differs: counter increments. When it reaches DEBOUNCE_SCANS, stable flips and the counter clears.
  - A value therefore changes DEBOUNCE_SCANS frames after a clean transition.
  - Any bounce that returns to the stable value resets the count.
- Output timing:
  - sense_sw and ctl_level update on the edge after their row's sample (registered, latency 1 clk).
  - ctl_pulse[i] is high for exactly one clk, the same cycle ctl_level[i] rises. There is no pulse on release.
  - Several control bits flipping in one frame give simultaneous pulses; no prioritisation is done here.
  - frame_done fires in the same cycle as the row 2 updates.
- Holding a switch closed produces no further pulses; auto-repeat is out of scope.
- Counters wrap only through their explicit clears; the row index never takes value 3 (treated as 0 if reached).

Decomposition:
- Shared package (front_panel_pkg):
  - Row indices ROW_ADDR_LO=0, ROW_ADDR_HI=1, ROW_CTL=2.
  - Control bit constants CTL_STOP..CTL_PANEL_RESET.
  - NUM_ROWS=3, NUM_COLS=8.
- One sub-module, switch_debounce: a single-bit stable/counter cell parameterized by DEBOUNCE_SCANS, with a sample-enable input and a rise-pulse output. It is instantiated 24 times.
- Scan FSM, synchronizer and output registers live in the top of this block.

Test Plan (ROW_CYCLES=8, DEBOUNCE_SCANS=3, frame=24 clk):
- Reset, col_n=8'hFF, run 10 frames -> row_n cycles 110,101,011 each for 8 clk; all outputs 0; frame_done every 24 clk.
- Row 0 reads 8'h5A closed and row 1 reads 8'hC3 (col_n inverted while each row is driven) -> sense_sw=16'hC35A exactly 3 frames after the stimulus is first sampled; no change before that.
- Control bit 3 (examine) closed and held 20 frames -> ctl_level[3] rises after 3 frames; ctl_pulse=8'h08 for exactly 1 clk; no further pulses; on release ctl_level[3] falls 3 frames later with no pulse.
- Bounce: bit 5 toggled so samples alternate 1,1,0,1,1,0 -> ctl_level[5] never rises; then held 1 -> rises after 3 frames with a single pulse.
- Bits 0 and 1 closed in the same frame -> ctl_pulse=8'h03 in one cycle.
- Assert resetn=0 mid-row 1 while sense_sw=16'hFFFF -> all outputs 0 and row_n=3'b111 immediately, without a clk edge; after release, scanning restarts at row 0.
